// File: rtl/recording_playback_reader.sv
// Replays recorded {key_mask, duration_ms} words from the recording buffer as a timed key mask.
// Build option PLAYBACK_LOOP_EN: wrap to record 0 after the last record instead of stopping.
module recording_playback_reader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int KEY_COUNT      = 6,
  parameter int DURATION_WIDTH = 10
) (
  input  logic                  clock_50Mhz,
  input  logic                  reset,
  input  logic                  tick_1kHz,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] record_length,
  output logic                  mem_read_req,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_read_valid,
  input  logic [15:0]           mem_read_data,
  output logic [KEY_COUNT-1:0]  output_KeyMask,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    PLAY
  } readerState;

  readerState                state, stateNext;
  logic [ADDR_WIDTH-1:0]     index, indexNext;
  logic [ADDR_WIDTH-1:0]     length, lengthNext;
  logic [DURATION_WIDTH-1:0] count, countNext;
  logic [KEY_COUNT-1:0]      mask, maskNext;
  logic                      doneReg, doneNext;
  logic                      lastRecord;
  logic [DURATION_WIDTH-1:0] recDuration;

  assign lastRecord  = (index == length - ADDR_WIDTH'(1));
  assign recDuration = mem_read_data[DURATION_WIDTH-1:0];

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      state   <= IDLE;
      index   <= '0;
      length  <= '0;
      count   <= '0;
      mask    <= '0;
      doneReg <= 1'b0;
    end else begin
      state   <= stateNext;
      index   <= indexNext;
      length  <= lengthNext;
      count   <= countNext;
      mask    <= maskNext;
      doneReg <= doneNext;
    end
  end

  always_comb begin
    stateNext  = state;
    indexNext  = index;
    lengthNext = length;
    countNext  = count;
    maskNext   = mask;
    doneNext   = 1'b0;
    // stop outranks everything, including a simultaneous start from IDLE
    if (stop) begin
      if (state != IDLE) begin
        stateNext = IDLE;
        maskNext  = '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (record_length == '0) begin
              doneNext = 1'b1;
            end else begin
              lengthNext = record_length;
              indexNext  = '0;
              stateNext  = FETCH;
            end
          end
        end
        FETCH: stateNext = WAIT;
        WAIT: begin
          if (mem_read_valid) begin
            maskNext  = mem_read_data[15 -: KEY_COUNT];
            countNext = (recDuration == '0) ? DURATION_WIDTH'(1) : recDuration;
            stateNext = PLAY;
          end
        end
        PLAY: begin
          if (tick_1kHz) begin
            if (count == DURATION_WIDTH'(1)) begin
              if (lastRecord) begin
                doneNext = 1'b1;
`ifdef PLAYBACK_LOOP_EN
                indexNext = '0;
                stateNext = FETCH;
`else
                maskNext  = '0;
                stateNext = IDLE;
`endif
              end else begin
                indexNext = index + ADDR_WIDTH'(1);
                stateNext = FETCH;
              end
            end else begin
              countNext = count - DURATION_WIDTH'(1);
            end
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign mem_read_req   = (state == FETCH);
  assign mem_address    = index;
  assign output_KeyMask = mask;
  assign busy           = (state != IDLE);
  assign done           = doneReg;

endmodule

// File: tb/tb_recording_playback_reader.sv
// Directed bench for recording_playback_reader: record-level reference model, per-cycle compare,
// plus literal expectations on request addresses, tick counts per mask and done pulses.
module tb_recording_playback_reader;

  localparam int AW = 12;
  localparam int TP = 16;  // cycles per 1 ms tick, shortened from 50,000 to keep the run small

  logic          clk = 1'b0;
  logic          reset = 1'b1, tick = 1'b0, start = 1'b0, stop = 1'b0;
  logic [AW-1:0] recordLength = '0;
  logic          memReadReq, memReadValid, busy, done;
  logic [AW-1:0] memAddress;
  logic [15:0]   memReadData;
  logic [5:0]    keyMask;

  logic          respValid = 1'b0, manValid = 1'b0;
  logic [15:0]   respData = '0, manData = '0;
  logic [15:0]   mem [0:15];
  int            latency = 2;

  assign memReadValid = respValid | manValid;
  assign memReadData  = manValid ? manData : respData;

  recording_playback_reader #(
    .ADDR_WIDTH(AW),
    .KEY_COUNT(6),
    .DURATION_WIDTH(10)
  ) dut (
    .clock_50Mhz(clk),
    .reset(reset),
    .tick_1kHz(tick),
    .start(start),
    .stop(stop),
    .record_length(recordLength),
    .mem_read_req(memReadReq),
    .mem_address(memAddress),
    .mem_read_valid(memReadValid),
    .mem_read_data(memReadData),
    .output_KeyMask(keyMask),
    .busy(busy),
    .done(done)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // free-running 1 ms strobe
  initial begin
    int div = 0;
    forever begin
      @(posedge clk);
      #1;
      div = (div == TP - 1) ? 0 : div + 1;
      tick = (div == 0);
    end
  end

  // buffer read port: answers each request after 'latency' cycles
  initial begin
    logic [3:0] a;
    forever begin
      @(negedge clk);
      if (memReadReq === 1'b1) begin
        a = memAddress[3:0];
        repeat (latency) @(posedge clk);
        #1;
        respValid = 1'b1;
        respData  = mem[a];
        @(posedge clk);
        #1;
        respValid = 1'b0;
      end
    end
  end

  // reference model: which record is active, how many ticks it has left, what it shows
  logic       mActive = 1'b0, mFetch = 1'b0, mAwait = 1'b0, mDone = 1'b0;
  int         mRec = 0, mLen = 0, mLeft = 0;
  logic [5:0] mMask = '0;

  initial forever begin
    @(posedge clk);
    mDone = 1'b0;
    if (reset) begin
      mActive = 1'b0; mFetch = 1'b0; mAwait = 1'b0; mRec = 0; mMask = '0;
    end else if (stop) begin
      if (mActive) begin
        mActive = 1'b0; mFetch = 1'b0; mAwait = 1'b0; mMask = '0;
      end
    end else if (!mActive) begin
      if (start) begin
        if (recordLength == '0) mDone = 1'b1;
        else begin
          mActive = 1'b1; mLen = int'(recordLength); mRec = 0; mFetch = 1'b1;
        end
      end
    end else if (mFetch) begin
      mFetch = 1'b0; mAwait = 1'b1;
    end else if (mAwait) begin
      if (memReadValid) begin
        mMask  = memReadData[15:10];
        mLeft  = (memReadData[9:0] == 10'd0) ? 1 : int'(memReadData[9:0]);
        mAwait = 1'b0;
      end
    end else if (tick) begin
      mLeft--;
      if (mLeft == 0) begin
        if (mRec == mLen - 1) begin
          mDone = 1'b1;
`ifdef PLAYBACK_LOOP_EN
          mRec = 0; mFetch = 1'b1;
`else
          mActive = 1'b0; mMask = '0;
`endif
        end else begin
          mRec++; mFetch = 1'b1;
        end
      end
    end
  end

  // per-cycle compare against the model, plus event logs for literal checks
  logic cmpEn = 1'b0;
  int   addrLog[$];
  int   doneCnt = 0;
  int   ticksAt[64];

  initial forever begin
    @(negedge clk);
    if (cmpEn) begin
      check("req", memReadReq, mFetch);
      if (mFetch) check("addr", memAddress, mRec);
      check("mask", keyMask, mMask);
      check("busy", busy, mActive);
      check("done", done, mDone);
    end
    if (memReadReq === 1'b1) addrLog.push_back(int'(memAddress));
    if (done === 1'b1) doneCnt++;
    if (tick && busy === 1'b1) ticksAt[keyMask]++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    addrLog.delete();
    doneCnt = 0;
    for (int i = 0; i < 64; i++) ticksAt[i] = 0;
  endtask

  task automatic pulseStart(input int len);
    start = 1'b1;
    recordLength = AW'(len);
    cyc(1);
    start = 1'b0;
  endtask

  task automatic waitTick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 4 * TP);
    check("tickSeen", tick, 1);
    cyc(1);
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < budget);
    check("doneSeen", done, 1);
  endtask

  task automatic waitMask(input logic [5:0] v, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (keyMask !== v && n < budget);
    check("maskReached", keyMask, v);
  endtask

  task automatic checkQuiet(input string tag);
    @(negedge clk);
    check({tag, ".req"}, memReadReq, 0);
    check({tag, ".addr"}, memAddress, 0);
    check({tag, ".mask"}, keyMask, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    cyc(3);
    checkQuiet("reset");
    cyc(1);
    reset = 1'b0;
    cmpEn = 1'b1;
    cyc(2);

    // three records, latency 2
    mem[0] = 16'h0403; mem[1] = 16'h8002; mem[2] = 16'h0001;
    latency = 2;
    clearLogs();
    waitTick();
    pulseStart(3);
    @(negedge clk);
    check("t1.reqAfterStart", memReadReq, 1);
    waitDone(300);
    check("t1.busyWithDone", busy, 0);
    cyc(3);
    check("t1.reqCount", addrLog.size(), 3);
    if (addrLog.size() == 3) begin
      check("t1.addr0", addrLog[0], 0);
      check("t1.addr1", addrLog[1], 1);
      check("t1.addr2", addrLog[2], 2);
    end
    check("t1.ticks01", ticksAt[6'h01], 3);
    check("t1.ticks20", ticksAt[6'h20], 2);
    check("t1.ticks00", ticksAt[6'h00], 1);
    check("t1.doneCnt", doneCnt, 1);

    // zero-length start
    clearLogs();
    pulseStart(0);
    @(negedge clk);
    check("t2.done", done, 1);
    check("t2.busy", busy, 0);
    cyc(5);
    check("t2.reqCount", addrLog.size(), 0);
    check("t2.doneCnt", doneCnt, 1);

    // single record with zero duration
    mem[0] = 16'h1800;
    clearLogs();
    waitTick();
    pulseStart(1);
    waitDone(200);
    check("t3.maskAtDone", keyMask, 0);
    cyc(3);
    check("t3.ticks06", ticksAt[6'h06], 1);
    check("t3.doneCnt", doneCnt, 1);

    // stop mid-play of record 1, then a stray valid
    mem[0] = 16'h0401; mem[1] = 16'h0803; mem[2] = 16'h1001; mem[3] = 16'h2001;
    clearLogs();
    pulseStart(4);
    waitMask(6'h02, 200);
    cyc(1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    @(negedge clk);
    check("t4.maskAfterStop", keyMask, 0);
    check("t4.busyAfterStop", busy, 0);
    cyc(1);
    manValid = 1'b1;
    manData  = 16'hFC05;
    cyc(1);
    manValid = 1'b0;
    @(negedge clk);
    check("t4.maskLateValid", keyMask, 0);
    check("t4.busyLateValid", busy, 0);
    cyc(30);
    check("t4.doneCnt", doneCnt, 0);
    check("t4.reqCount", addrLog.size(), 2);

    // start and stop together from IDLE
    clearLogs();
    start = 1'b1; stop = 1'b1; recordLength = AW'(3);
    cyc(1);
    start = 1'b0; stop = 1'b0;
    cyc(20);
    check("t5a.reqCount", addrLog.size(), 0);
    check("t5a.busy", busy, 0);
    check("t5a.doneCnt", doneCnt, 0);

    // restart attempt while playing
    mem[0] = 16'h0403; mem[1] = 16'h8002; mem[2] = 16'h0001;
    latency = 1;
    clearLogs();
    waitTick();
    pulseStart(3);
    waitMask(6'h01, 50);
    cyc(2);
    pulseStart(1);
    waitDone(300);
    cyc(3);
    check("t5b.reqCount", addrLog.size(), 3);
    if (addrLog.size() == 3) begin
      check("t5b.addr1", addrLog[1], 1);
      check("t5b.addr2", addrLog[2], 2);
    end
    check("t5b.doneCnt", doneCnt, 1);

    // reset while waiting for a slow read
    latency = 8;
    clearLogs();
    pulseStart(3);
    cyc(3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    checkQuiet("t5c");
    cyc(20);
    check("t5c.maskAfterLateValid", keyMask, 0);
    check("t5c.busyAfterLateValid", busy, 0);

`ifdef PLAYBACK_LOOP_EN
    // looping playback over two records
    mem[0] = 16'h0401; mem[1] = 16'h0801;
    latency = 2;
    clearLogs();
    pulseStart(2);
    begin
      int n = 0;
      while (addrLog.size() < 5 && n < 400) begin
        @(negedge clk);
        n++;
      end
    end
    cyc(2);
    check("t6.reqCount", addrLog.size(), 5);
    if (addrLog.size() >= 5) begin
      check("t6.addr0", addrLog[0], 0);
      check("t6.addr1", addrLog[1], 1);
      check("t6.addr2", addrLog[2], 0);
      check("t6.addr3", addrLog[3], 1);
      check("t6.addr4", addrLog[4], 0);
    end
    check("t6.doneCnt", doneCnt, 2);
    check("t6.busy", busy, 1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    @(negedge clk);
    check("t6.busyAfterStop", busy, 0);
    cyc(12);
`endif

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/recording_playback_reader.md
Name: recording_playback_reader

Overview:
- Reads key-event records back out of the recording buffer and replays them as a 6-key mask with the original timing.
- The buffer is written by the recording writer during MakeRecording.
- Sits beside the music-keys path. The state controller starts and stops it in PlayRecording state, and its key-mask output feeds the tone generator in place of the live keys.
- Timing comes from the 1 kHz tick; memory access is a simple request/valid read port into the buffer.

Parameters:
- ADDR_WIDTH, 12, buffer address width; max records = 2^ADDR_WIDTH - 1.
- KEY_COUNT, 6, key-mask width; record bits [15:16-KEY_COUNT].
- DURATION_WIDTH, 10, duration field width; record bits [DURATION_WIDTH-1:0]; KEY_COUNT + DURATION_WIDTH = 16.

Ports:
- clock_50Mhz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick_1kHz  in  1  single-cycle strobe, once per ms, synchronous to clock_50Mhz.
- start  in  1  single-cycle pulse; begin playback at address 0.
- stop  in  1  single-cycle pulse; abort playback.
- record_length  in  ADDR_WIDTH  number of valid records; sampled only when start is accepted.
- mem_read_req  out  1  one-cycle read request.
- mem_address  out  ADDR_WIDTH  read address; valid while req high, held until valid returns.
- mem_read_valid  in  1  read data valid strobe.
- mem_read_data  in  16  record word: {key_mask, duration_ms}.
- output_KeyMask  out  KEY_COUNT  replayed key mask, active-high.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on natural completion.

Behaviour:
- Reset (sync, active-high, overrides all inputs): state IDLE; mem_read_req=0, mem_address=0, output_KeyMask=0, busy=0, done=0; all counters cleared.
- FSM states: IDLE, FETCH, WAIT, PLAY.
- IDLE:
  - start with record_length != 0: latch length, set address 0, go to FETCH.
  - start with record_length == 0: pulse done in the next cycle; no memory read; stay IDLE.
- FETCH: mem_read_req=1 for exactly one cycle with mem_address = current index; next state WAIT.
- WAIT:
  - Hold mem_address; mem_read_req=0.
  - On mem_read_valid: in that same cycle load output_KeyMask = data[15:10] and duration counter = data[9:0]. A duration of 0 is treated as 1. Next state PLAY.
  - Memory latency is unbounded (>=1 cycle).
- PLAY:
  - Each tick_1kHz decrements the counter.
  - Counter reaches 0 and index < length-1: increment index, go to FETCH. output_KeyMask holds its value through FETCH/WAIT until the next record loads, so there are no glitches to 0 between records.
  - Counter reaches 0 and index == length-1: output_KeyMask=0, done=1 for one cycle, go to IDLE.
- A tick in the same cycle as mem_read_valid is not counted against the new record; counting starts at the next tick.
- Ticks during FETCH/WAIT are ignored. The per-record skew is a few 50 MHz cycles, which is acceptable.
- mem_read_valid outside WAIT is ignored.
- stop in any non-IDLE state: next cycle IDLE, output_KeyMask=0, mem_read_req=0, no done pulse. An outstanding read whose valid arrives later is ignored.
- start while busy is ignored.
- start and stop in the same cycle: stop wins. From IDLE this means nothing happens.
- Index and length are ADDR_WIDTH bits; the index never exceeds length-1, so there is no wrap in the base build.
- Playback end-to-end latency: start → mem_read_req high 1 cycle later.

Optional Feature:
- Macro: PLAYBACK_LOOP_EN.
- Defined:
  - At expiry of the last record, index returns to 0 and the FSM goes to FETCH instead of IDLE.
  - done pulses once per completed pass, in the same cycle as the wrap; busy stays high.
  - output_KeyMask holds until record 0 loads.
  - Only stop or reset ends playback.
- Undefined: single pass as described above. The macro affects only this end-of-list transition.

Test Plan:
1. 3 records {6'b000001,3},{6'b100000,2},{6'b000000,1}, length=3, memory latency 2 cycles, ticks every 50,000 cycles →
   - output_KeyMask 01h for 3 ticks, 20h for 2 ticks, 00h for 1 tick;
   - exactly 3 mem_read_req pulses at addresses 0,1,2;
   - done pulses once; busy falls in the same cycle as done.
2. start with record_length=0 → no mem_read_req; done=1 exactly one cycle later; busy stays 0.
3. Record {6'b000110,0} with length=1 → mask 06h held for 1 tick, then 00h plus done.
4. stop mid-PLAY of record 1 (of 4), then assert a late mem_read_valid →
   - next cycle IDLE, mask 00h, no done;
   - the late valid does not change any output.
5. Edge cases:
   - start and stop in the same cycle from IDLE → no activity.
   - start pulsed again during PLAY → ignored; address sequence unchanged.
   - reset asserted during WAIT → all outputs 0 on the next edge.
6. With PLAYBACK_LOOP_EN, length=2 → address sequence 0,1,0,1…; done pulses once per pass; busy stays 1 until stop.
